uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
Boot-time sequencer between the UART receiver and the instruction memory of the RISC-V core. It assembles received bytes into 32-bit little-endian instruction words and writes them to consecutive instruction-memory word addresses starting at 0. The load ends on a sentinel word, on memory full, or on a reload request. The core is held in reset for the whole load and released when write_done rises.

Parameters:
ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words
END_WORD, 32'hFFFF_FFFF, sentinel word that terminates loading; the sentinel is never written
GAP_TIMEOUT, 1000000, idle clk cycles allowed between bytes of one word before the partial word is discarded; 0 disables the timeout
CNT_W, 20, width of the gap-timeout counter; must hold GAP_TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
uart_rx_valid  in  1  one-cycle strobe: a received byte is present on uart_rx_data
uart_rx_data  in  8  received byte
uart_rx_break  in  1  BREAK detected by the UART
reload  in  1  one-cycle request to start a new load
imem_we  out  1  instruction-memory write strobe, one cycle
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  assembled instruction word
cpu_rst  out  1  reset to the core; high while loading
write_done  out  1  load complete; held high until reset or reload
overflow  out  1  sticky flag: memory filled before the sentinel arrived
err_count  out  8  saturating count of discarded partial words

Behaviour:
- Reset values: state=LOAD, byte_idx=0, addr=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, write_done=0, overflow=0, err_count=0, timeout counter=0.
- FSM states: LOAD, DONE.
- LOAD: on each uart_rx_valid, store uart_rx_data into word byte lane byte_idx (lane 0 = bits 7:0), then byte_idx+1.
- On the 4th byte, with byte_idx==3:
  - If the assembled word equals END_WORD: next cycle write_done=1, cpu_rst=0, state=DONE. No write.
  - Otherwise: next cycle imem_we=1, imem_addr=addr, imem_wdata=word. addr increments after the write. byte_idx returns to 0.
- Write latency is exactly 1 clk after the 4th byte's uart_rx_valid cycle.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- A uart_rx_valid arriving in the same cycle as an imem_we pulse is accepted into lane 0.
- Memory full:
  - When a write lands at addr = 2**ADDR_W-1, the cycle after that write sets overflow=1, write_done=1, cpu_rst=0 and moves to DONE.
  - addr never wraps.
- Gap timeout, active only when byte_idx!=0:
  - The counter clears on every uart_rx_valid and increments otherwise.
  - When it reaches GAP_TIMEOUT, byte_idx=0, the partial word is dropped and err_count increments (saturates at 255).
  - addr is unchanged.
- uart_rx_break in LOAD: same discard action as a timeout, but only when byte_idx!=0. With byte_idx==0 it has no effect.
- If uart_rx_valid and uart_rx_break occur in the same cycle, the break applies first and the byte is taken as lane 0.
- DONE:
  - uart_rx_valid and uart_rx_break are ignored.
  - reload returns to LOAD with addr=0, byte_idx=0, write_done=0, cpu_rst=1 and overflow=0. err_count is kept.
  - The new outputs are visible the next cycle.
- reload in LOAD is ignored.
- rst asserted at any time, including mid-word or mid-write, forces all reset values immediately (asynchronous). No write is produced for the interrupted word.
- cpu_rst == ~write_done at all times.

Test Plan:
- Bytes 00,00,00,00 then 13,01,01,fa -> imem_we pulses at addr 0 data 0x00000000 and addr 1 data 0xfa010113, each 1 clk after the 4th byte; cpu_rst stays 1.
- Words 0x00000000, 0xfa010113, then ff,ff,ff,ff -> exactly 2 writes; write_done=1 and cpu_rst=0 one clk after the last ff; a following 0x12345678 is ignored (no imem_we).
- GAP_TIMEOUT=100: send 13,01, idle 100 clk, then 13,01,01,fa -> err_count=1; single write of 0xfa010113 at addr 0.
- ADDR_W=2: send 5 non-sentinel words -> writes to addr 0..3; overflow=1 and write_done=1 after the 4th write; 5th word ignored.
- Assert rst after 2 bytes of the 3rd word -> outputs return to reset values; next full word is written at addr 0.
- From DONE, pulse reload and send 0xdeadbeef then the sentinel -> write_done drops, write at addr 0 data 0xdeadbeef, write_done rises again; err_count is kept.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs UART bytes into little-endian 32-bit words
// and streams them into instruction memory while holding the core in reset.
module uart_prog_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int          GAP_TIMEOUT = 1000000,
  parameter int          CNT_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              write_done,
  output logic              overflow,
  output logic [7:0]        err_count
);

  typedef enum logic {LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [CNT_W-1:0]  GAP_LIM = CNT_W'(GAP_TIMEOUT);

  state_t            state;
  logic [1:0]        byte_idx;
  logic [23:0]       part;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  gap_cnt;
  logic              full_pend;

  logic [31:0] word;
  logic        gap_hit;
  logic        discard;

  // Current word if this byte completes it, plus partial-word drop causes
  always_comb begin
    word    = {uart_rx_data, part};
    gap_hit = (GAP_TIMEOUT != 0) && !uart_rx_valid
              && (gap_cnt == GAP_LIM - 1'b1);
    discard = (byte_idx != 2'd0) && (uart_rx_break || gap_hit);
  end

  // Load sequencer: byte assembly, writes, termination and reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      byte_idx   <= 2'd0;
      part       <= '0;
      addr       <= '0;
      gap_cnt    <= '0;
      full_pend  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      write_done <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (full_pend) begin
            // last slot was just written; memory is full
            full_pend  <= 1'b0;
            overflow   <= 1'b1;
            write_done <= 1'b1;
            cpu_rst    <= 1'b0;
            byte_idx   <= 2'd0;
            gap_cnt    <= '0;
            state      <= DONE;
          end else begin
            if (discard) begin
              byte_idx <= 2'd0;
              gap_cnt  <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (uart_rx_valid) begin
              gap_cnt <= '0;
              if (discard || byte_idx == 2'd0) begin
                part[7:0] <= uart_rx_data;
                byte_idx  <= 2'd1;
              end else if (byte_idx == 2'd1) begin
                part[15:8] <= uart_rx_data;
                byte_idx   <= 2'd2;
              end else if (byte_idx == 2'd2) begin
                part[23:16] <= uart_rx_data;
                byte_idx    <= 2'd3;
              end else begin
                byte_idx <= 2'd0;
                if (word == END_WORD) begin
                  write_done <= 1'b1;
                  cpu_rst    <= 1'b0;
                  state      <= DONE;
                end else begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr;
                  imem_wdata <= word;
                  if (addr == LAST) full_pend <= 1'b1;
                  else addr <= addr + 1'b1;
                end
              end
            end else if (!discard && byte_idx != 2'd0
                         && GAP_TIMEOUT != 0) begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (reload) begin
            state      <= LOAD;
            addr       <= '0;
            byte_idx   <= 2'd0;
            gap_cnt    <= '0;
            write_done <= 1'b0;
            cpu_rst    <= 1'b1;
            overflow   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: scoreboard bench for the UART program loader.
// Small memory (ADDR_W=2) and short gap timeout (100) for fast coverage.
module tb_uart_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       reload;
  logic       imem_we;
  logic [1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_rst;
  logic       write_done;
  logic       overflow;
  logic [7:0] err_count;

  uart_prog_loader #(
    .ADDR_W(2),
    .END_WORD(32'hFFFF_FFFF),
    .GAP_TIMEOUT(100),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break),
    .reload(reload),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .write_done(write_done),
    .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_writes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", imem_addr,
                 imem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data
            || cyc !== e.cyc) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // all stimulus tasks start and end at posedge+1
  task automatic send_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit exp,
                           input logic [1:0] a);
    exp_t e;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    if (exp) begin
      e.addr = a;
      e.data = w;
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    sb.delete();
    n_writes = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data = 8'h00;
    uart_rx_break = 1'b0;
    reload = 1'b0;
    idle(3);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, cpu_rst, write_done, overflow,
         err_count} !== {1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_values got we=%b a=%0d d=%h cr=%b wd=%b ov=%b ec=%0d",
               imem_we, imem_addr, imem_wdata, cpu_rst, write_done,
               overflow, err_count);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (imem_we !== 1'b0 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset we=%b cpu_rst=%b exp 0 1",
               imem_we, cpu_rst);
    end
  endtask

  task automatic test_writes_and_sentinel();
    send_word(32'h0000_0000, 1, 2'd0);
    send_word(32'hfa01_0113, 1, 2'd1);
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || write_done !== 1'b0) begin
      failures++;
      $display("FAIL loading_cpu_rst got cr=%b wd=%b exp 1 0",
               cpu_rst, write_done);
    end
    @(posedge clk); #1;
    send_word(32'hFFFF_FFFF, 0, 2'd0);
    checks++;
    if (write_done !== 1'b1 || cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL sentinel_done got wd=%b cr=%b exp 1 0",
               write_done, cpu_rst);
    end
    send_word(32'h1234_5678, 0, 2'd0);
    idle(3);
    checks++;
    if (n_writes !== 2) begin
      failures++;
      $display("FAIL write_count got %0d exp 2", n_writes);
    end
  endtask

  task automatic test_gap_and_break();
    do_reset();
    send_byte(8'h13);
    send_byte(8'h01);
    idle(100);
    checks++;
    if (err_count !== 8'd1) begin
      failures++;
      $display("FAIL gap_timeout err_count got %0d exp 1", err_count);
    end
    send_word(32'hfa01_0113, 1, 2'd0);
    send_byte(8'haa);
    uart_rx_break = 1'b1;
    idle(1);
    uart_rx_break = 1'b0;
    checks++;
    if (err_count !== 8'd2) begin
      failures++;
      $display("FAIL break_discard err_count got %0d exp 2", err_count);
    end
    uart_rx_break = 1'b1;
    idle(1);
    uart_rx_break = 1'b0;
    checks++;
    if (err_count !== 8'd2) begin
      failures++;
      $display("FAIL break_idle err_count got %0d exp 2", err_count);
    end
    send_byte(8'haa);
    send_byte(8'hbb);
    uart_rx_break = 1'b1;
    send_byte(8'h13);
    uart_rx_break = 1'b0;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hfa);
    sb.push_back('{addr: 2'd1, data: 32'hfa01_0113, cyc: cyc});
    checks++;
    if (err_count !== 8'd3) begin
      failures++;
      $display("FAIL break_with_byte err_count got %0d exp 3", err_count);
    end
    idle(2);
  endtask

  task automatic test_full();
    do_reset();
    send_byte(8'h55);
    uart_rx_break = 1'b1;
    idle(1);
    uart_rx_break = 1'b0;
    for (int i = 0; i < 4; i++)
      send_word(32'h1111_1111 * (i + 1), 1, 2'(i));
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || write_done !== 1'b0) begin
      failures++;
      $display("FAIL full_early got ov=%b wd=%b exp 0 0",
               overflow, write_done);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || write_done !== 1'b1 || cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL full_done got ov=%b wd=%b cr=%b exp 1 1 0",
               overflow, write_done, cpu_rst);
    end
    @(posedge clk); #1;
    send_word(32'h5555_5555, 0, 2'd0);
    idle(3);
    checks++;
    if (n_writes !== 4) begin
      failures++;
      $display("FAIL full_write_count got %0d exp 4", n_writes);
    end
  endtask

  task automatic test_reload();
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
    checks++;
    if (write_done !== 1'b0 || cpu_rst !== 1'b1 || overflow !== 1'b0
        || err_count !== 8'd1) begin
      failures++;
      $display("FAIL reload got wd=%b cr=%b ov=%b ec=%0d exp 0 1 0 1",
               write_done, cpu_rst, overflow, err_count);
    end
    send_word(32'hdead_beef, 1, 2'd0);
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
    send_word(32'hFFFF_FFFF, 0, 2'd0);
    checks++;
    if (write_done !== 1'b1 || cpu_rst !== 1'b0 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL reload_done got wd=%b cr=%b ec=%0d exp 1 0 1",
               write_done, cpu_rst, err_count);
    end
  endtask

  task automatic test_rst_midword();
    do_reset();
    send_word(32'h0000_0093, 1, 2'd0);
    send_word(32'h0010_0113, 1, 2'd1);
    send_byte(8'h37);
    send_byte(8'h02);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 2'd0 || imem_wdata !== 32'd0 || cpu_rst !== 1'b1
        || write_done !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got a=%0d d=%h cr=%b wd=%b exp 0 0 1 0",
               imem_addr, imem_wdata, cpu_rst, write_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(32'h00c0_ffee, 1, 2'd0);
    idle(1);
    send_word(32'h0102_0304, 0, 2'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_write imem_we got %b exp 0", imem_we);
    end
    idle(1);
    rst = 1'b0;
    send_word(32'h0bad_cafe, 1, 2'd0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_writes_and_sentinel();
    test_gap_and_break();
    test_full();
    test_reload();
    test_rst_midword();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got %0d pending exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
